// File: rtl/me_search_loader_if.sv
// Bus bundle for the motion-estimation search loader: pixel load stream,
// reference/search memory read ports and the estimator run/result handshake.
interface me_search_loader_if;
  logic       load;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] AddressR;
  logic [9:0] AddressS1;
  logic [9:0] AddressS2;
  logic [7:0] R;
  logic [7:0] s1;
  logic [7:0] s2;
  logic       start;
  logic [3:0] motionx;
  logic [3:0] motiony;
  logic [3:0] result_x;
  logic [3:0] result_y;
  logic       result_valid;
  logic       busy;

  // Environment side: feeds pixels, read addresses and estimator results.
  modport master (
    output load, pix_in, pix_valid, AddressR, AddressS1, AddressS2, motionx, motiony,
    input  pix_ready, R, s1, s2, start, result_x, result_y, result_valid, busy
  );

  // Loader side.
  modport slave (
    input  load, pix_in, pix_valid, AddressR, AddressS1, AddressS2, motionx, motiony,
    output pix_ready, R, s1, s2, start, result_x, result_y, result_valid, busy
  );
endinterface

// File: rtl/me_search_loader.sv
// Loads a 16x16 reference block and a 31x31 search window from a byte stream,
// serves them through combinational read ports, runs the estimator for a fixed
// number of cycles and captures its motion vector.
module me_search_loader #(
  parameter int RUN_CYCLES = 4112
) (
  input  logic          clock,
  input  logic          reset,
  me_search_loader_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_R = 3'd1;
  localparam logic [2:0] LOAD_S = 3'd2;
  localparam logic [2:0] RUN    = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam int          S_DEPTH = 961;
  localparam logic [9:0]  S_LAST  = 10'd960;
  localparam logic [9:0]  R_LAST  = 10'd255;
  localparam int          CNT_W   = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);

  logic [2:0]       state;
  logic [9:0]       load_idx;
  logic [CNT_W-1:0] run_cnt;
  logic             start_q;
  logic             result_valid_q;
  logic [3:0]       result_x_q;
  logic [3:0]       result_y_q;
  logic             loading;
  logic             xfer;

  logic [7:0] rmem [256];
  logic [7:0] smem [S_DEPTH];

  assign loading = (state == LOAD_R) || (state == LOAD_S);
  assign xfer    = loading && bus.pix_valid;

  assign bus.pix_ready    = loading;
  assign bus.busy         = (state != IDLE);
  assign bus.start        = start_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_x     = result_x_q;
  assign bus.result_y     = result_y_q;

  // Combinational reads; addresses past the window end read as zero.
  assign bus.R  = rmem[bus.AddressR];
  assign bus.s1 = (bus.AddressS1 <= S_LAST) ? smem[bus.AddressS1] : 8'h00;
  assign bus.s2 = (bus.AddressS2 <= S_LAST) ? smem[bus.AddressS2] : 8'h00;

  // Pixel writes; memory is never cleared and reset blocks a same-cycle write.
  always_ff @(posedge clock) begin
    if (!reset && xfer) begin
      if (state == LOAD_R) begin
        rmem[load_idx[7:0]] <= bus.pix_in;
      end else begin
        smem[load_idx] <= bus.pix_in;
      end
    end
  end

  // Control FSM: load both memories, hold start for the run, capture result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      load_idx       <= '0;
      run_cnt        <= '0;
      start_q        <= 1'b0;
      result_valid_q <= 1'b0;
      result_x_q     <= 4'h0;
      result_y_q     <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            state    <= LOAD_R;
            load_idx <= '0;
          end
        end
        LOAD_R: begin
          if (xfer) begin
            if (load_idx == R_LAST) begin
              state    <= LOAD_S;
              load_idx <= '0;
            end else begin
              load_idx <= load_idx + 10'd1;
            end
          end
        end
        LOAD_S: begin
          if (xfer) begin
            if (load_idx == S_LAST) begin
              state    <= RUN;
              load_idx <= '0;
              run_cnt  <= '0;
              start_q  <= 1'b1;
            end else begin
              load_idx <= load_idx + 10'd1;
            end
          end
        end
        RUN: begin
          if (run_cnt == RUN_LAST) begin
            state          <= DONE;
            run_cnt        <= '0;
            start_q        <= 1'b0;
            result_valid_q <= 1'b1;
            result_x_q     <= bus.motionx;
            result_y_q     <= bus.motiony;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        DONE: begin
          state          <= IDLE;
          result_valid_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          start_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_me_search_loader.sv
// Scoreboard bench for me_search_loader: reference memory images and expected
// motion results are modelled here and compared against the DUT outputs.
module tb_me_search_loader;
  localparam int RUN_CYCLES = 4112;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  me_search_loader_if bus();

  me_search_loader #(.RUN_CYCLES(RUN_CYCLES)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_r [256];
  logic [7:0] old_r [256];
  logic [7:0] exp_s [961];
  logic [7:0] res_q [$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.load = 1'b0; bus.pix_in = 8'h00; bus.pix_valid = 1'b0;
    bus.AddressR = 8'h00; bus.AddressS1 = 10'd0; bus.AddressS2 = 10'd0;
    bus.motionx = 4'h0; bus.motiony = 4'h0;
  endtask

  task automatic pulse_load;
    bus.load = 1'b1;
    tick;
    bus.load = 1'b0;
  endtask

  task automatic random_pattern;
    for (int i = 0; i < 256; i++) exp_r[i] = 8'($urandom);
    for (int i = 0; i < 961; i++) exp_s[i] = 8'($urandom);
  endtask

  // Compare every memory location against the model (run only while IDLE).
  task automatic sweep_mem(input string tag);
    int bad_r = 0;
    int bad_s = 0;
    int fa = -1;
    logic [7:0] fg = 8'h00;
    logic [7:0] fe = 8'h00;
    for (int a = 0; a < 256; a++) begin
      bus.AddressR = 8'(a);
      #1;
      if (bus.R !== exp_r[a]) begin
        if (bad_r == 0) begin fa = a; fg = bus.R; fe = exp_r[a]; end
        bad_r++;
      end
    end
    tests++;
    if (bad_r != 0) begin
      fails++;
      $display("FAIL %s_rmem: %0d bad, addr %0d got %02h expected %02h", tag, bad_r, fa, fg, fe);
    end
    for (int a = 0; a < 961; a++) begin
      bus.AddressS1 = 10'(a);
      bus.AddressS2 = 10'(960 - a);
      #1;
      if (bus.s1 !== exp_s[a] || bus.s2 !== exp_s[960 - a]) begin
        if (bad_s == 0) begin fa = a; fg = bus.s1; fe = exp_s[a]; end
        bad_s++;
      end
    end
    tests++;
    if (bad_s != 0) begin
      fails++;
      $display("FAIL %s_smem: %0d bad, addr %0d s1 got %02h expected %02h", tag, bad_s, fa, fg, fe);
    end
    tick;
  endtask

  // Stream the model images into the DUT; optional stalls and a stray load.
  task automatic stream(input int gap_pct, input int load_at, input bit check_wr,
                        output int ready_cycles);
    int n = 0;
    int guard = 0;
    ready_cycles = 0;
    while (n < 1217 && guard < 20000) begin
      bus.load = (load_at >= 0 && n == load_at);
      if (bus.pix_ready === 1'b1) begin
        ready_cycles++;
        if ($urandom_range(99) < gap_pct) begin
          bus.pix_valid = 1'b0;
          bus.pix_in    = 8'($urandom);
        end else begin
          bus.pix_valid = 1'b1;
          bus.pix_in    = (n < 256) ? exp_r[n] : exp_s[n - 256];
          if (check_wr && n == 5) begin
            bus.AddressR = 8'd5;
            #1;
            tests++;
            if (bus.R !== old_r[5]) begin
              fails++;
              $display("FAIL write_read_old: R got %02h expected %02h", bus.R, old_r[5]);
            end
          end
          n++;
        end
      end else begin
        bus.pix_valid = 1'b0;
      end
      tick;
      guard++;
    end
    bus.pix_valid = 1'b0;
    bus.load      = 1'b0;
    if (n < 1217) begin
      tests++; fails++;
      $display("FAIL load_timeout: %0d pixels taken, expected 1217", n);
    end
  endtask

  // Count start cycles, then check the result pulse against the scoreboard.
  task automatic wait_run(input bit junk);
    int starts = 0;
    int guard = 0;
    logic [7:0] e = 8'h00;
    while (bus.start === 1'b1 && guard < 10000) begin
      if (junk) begin
        bus.load      = ((starts % 500) == 7);
        bus.pix_valid = 1'b1;
        bus.pix_in    = 8'($urandom);
      end
      starts++; guard++;
      tick;
    end
    bus.load = 1'b0; bus.pix_valid = 1'b0;
    tests++;
    if (starts != RUN_CYCLES) begin
      fails++;
      $display("FAIL run_length: start high %0d cycles, expected %0d", starts, RUN_CYCLES);
    end
    tests++;
    if (bus.result_valid !== 1'b1) begin
      fails++;
      $display("FAIL result_valid_rise: got %b expected 1", bus.result_valid);
    end else if (res_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_empty: result pulse with no expected entry");
    end else begin
      e = res_q.pop_front();
      tests++;
      if ({bus.result_x, bus.result_y} !== e) begin
        fails++;
        $display("FAIL result_capture: got %h%h expected %02h", bus.result_x, bus.result_y, e);
      end
    end
    tick;
    tests++;
    if (bus.result_valid !== 1'b0) begin
      fails++;
      $display("FAIL result_valid_width: got %b expected 0", bus.result_valid);
    end
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_after_done: got %b expected 0", bus.busy);
    end
    tests++;
    if ({bus.result_x, bus.result_y} !== e) begin
      fails++;
      $display("FAIL result_hold: got %h%h expected %02h", bus.result_x, bus.result_y, e);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.load = 1'b1;
    tick;
    bus.load = 1'b0;
    tick;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tests++; if (bus.pix_ready !== 1'b0) begin fails++; $display("FAIL reset_pix_ready: got %b expected 0", bus.pix_ready); end
    tests++; if (bus.start !== 1'b0) begin fails++; $display("FAIL reset_start: got %b expected 0", bus.start); end
    tests++; if (bus.result_valid !== 1'b0) begin fails++; $display("FAIL reset_result_valid: got %b expected 0", bus.result_valid); end
    tests++; if (bus.result_x !== 4'h0 || bus.result_y !== 4'h0) begin
      fails++; $display("FAIL reset_result: got %h%h expected 00", bus.result_x, bus.result_y);
    end
    rst = 1'b0;
    tick;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL idle_after_reset: busy %b expected 0", bus.busy); end
  endtask

  task automatic test_full_load;
    int rc;
    for (int i = 0; i < 256; i++) exp_r[i] = 8'(i);
    for (int i = 0; i < 961; i++) exp_s[i] = 8'(i % 256);
    bus.motionx = 4'h3; bus.motiony = 4'hC;
    res_q.push_back(8'h3C);
    pulse_load;
    stream(0, -1, 1'b0, rc);
    tests++; if (rc != 1217) begin fails++; $display("FAIL ready_cycles: got %0d expected 1217", rc); end
    tests++; if (bus.start !== 1'b1) begin fails++; $display("FAIL start_rise: got %b expected 1", bus.start); end
    tests++; if (bus.pix_ready !== 1'b0) begin fails++; $display("FAIL ready_in_run: got %b expected 0", bus.pix_ready); end
    bus.AddressR = 8'h10; bus.AddressS1 = 10'd700;
    #1;
    tests++; if (bus.R !== 8'h10) begin fails++; $display("FAIL r_at_10: got %02h expected 10", bus.R); end
    tests++; if (bus.s1 !== 8'hBC) begin fails++; $display("FAIL s1_at_700: got %02h expected bc", bus.s1); end
    wait_run(1'b0);
  endtask

  task automatic test_oob_reads;
    bus.AddressS1 = 10'd961; bus.AddressS2 = 10'd1023;
    #1;
    tests++; if (bus.s1 !== 8'h00) begin fails++; $display("FAIL s1_oob: got %02h expected 00", bus.s1); end
    tests++; if (bus.s2 !== 8'h00) begin fails++; $display("FAIL s2_oob: got %02h expected 00", bus.s2); end
    bus.AddressS2 = 10'd960;
    #1;
    tests++; if (bus.s2 !== 8'hC0) begin fails++; $display("FAIL s2_last: got %02h expected c0", bus.s2); end
    tick;
  endtask

  task automatic test_gap_load;
    int rc;
    old_r = exp_r;
    random_pattern;
    bus.motionx = 4'h5; bus.motiony = 4'hA;
    res_q.push_back(8'h5A);
    pulse_load;
    stream(40, -1, 1'b1, rc);
    tests++; if (bus.start !== 1'b1) begin fails++; $display("FAIL gap_start: got %b expected 1", bus.start); end
    wait_run(1'b1);
    sweep_mem("gap");
  endtask

  task automatic test_load_ignored;
    int rc;
    random_pattern;
    bus.motionx = 4'h9; bus.motiony = 4'h6;
    res_q.push_back(8'h96);
    pulse_load;
    stream(0, 600, 1'b0, rc);
    tests++; if (rc != 1217) begin fails++; $display("FAIL ignored_load_ready: got %0d expected 1217", rc); end
    wait_run(1'b1);
    sweep_mem("ignored");
  endtask

  task automatic test_reset_mid;
    int rc;
    logic [7:0] part [100];
    for (int i = 0; i < 100; i++) part[i] = 8'($urandom);
    pulse_load;
    for (int i = 0; i < 100; i++) begin
      bus.pix_valid = 1'b1; bus.pix_in = part[i];
      tick;
    end
    rst = 1'b1; bus.pix_in = ~exp_r[100];
    tick;
    bus.pix_valid = 1'b0;
    tests++; if (bus.pix_ready !== 1'b0) begin fails++; $display("FAIL midload_ready: got %b expected 0", bus.pix_ready); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midload_busy: got %b expected 0", bus.busy); end
    rst = 1'b0;
    tick;
    for (int i = 0; i < 100; i++) exp_r[i] = part[i];
    sweep_mem("midload");
    random_pattern;
    bus.motionx = 4'h7; bus.motiony = 4'h1;
    pulse_load;
    stream(0, -1, 1'b0, rc);
    repeat (50) tick;
    rst = 1'b1; bus.load = 1'b1;
    tick;
    bus.load = 1'b0;
    tests++; if (bus.start !== 1'b0) begin fails++; $display("FAIL midrun_start: got %b expected 0", bus.start); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrun_busy: got %b expected 0", bus.busy); end
    tests++; if (bus.result_x !== 4'h0 || bus.result_y !== 4'h0) begin
      fails++; $display("FAIL midrun_result: got %h%h expected 00", bus.result_x, bus.result_y);
    end
    rst = 1'b0;
    tick;
    sweep_mem("restart");
  endtask

  initial begin
    idle_inputs;
    rst = 1'b1;
    repeat (3) tick;
    test_reset;
    test_full_load;
    test_oob_reads;
    test_gap_load;
    test_load_ignored;
    test_reset_mid;
    tests++;
    if (res_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover: %0d entries expected 0", res_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
